gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives a combinational gate under test (such as the two-input AND gate) through every input combination. It samples the gate output for each combination and assembles the results into a truth-table register. It sits between a host's start/done handshake and the gate's input/output pins, so gate characterisation runs in hardware rather than in a testbench loop.

---
 rtl/gate_sweep_pkg.sv | 11 +
 rtl/gate_sweep_settle_timer.sv | 17 +
 rtl/gate_sweep_ctrl.sv | 86 ++++++++
 tb/tb_gate_sweep_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: sweep FSM states and counter width helpers shared by the gate sweep sequencer.
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  // One extra index bit lets the last vector be detected without wrapping.
  function automatic int idx_w(input int n_in);
    return n_in + 1;
  endfunction
  function automatic int cnt_w(input int settle_cyc);
    return settle_cyc > 1 ? $clog2(settle_cyc) : 1;
  endfunction
endpackage

// File: rtl/gate_sweep_settle_timer.sv
// gate_sweep_settle_timer: counts 0..SETTLE_CYC-1 with clear, tc marks the sampling cycle.
import gate_sweep_pkg::*;

module gate_sweep_settle_timer #(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);
  localparam int CW = cnt_w(SETTLE_CYC);
  logic [CW-1:0] cnt;
  assign tc = cnt == CW'(SETTLE_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr) ? '0 : tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives a gate through every input vector and builds its truth table.
// Defining GATE_SWEEP_CHECK_EN adds a result checker against the expected table.
import gate_sweep_pkg::*;

module gate_sweep_ctrl #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic [2**N_IN-1:0]   truth_table,
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch
);
  localparam int IW = idx_w(N_IN);
  localparam int TW = 2 ** N_IN;
  localparam logic [IW-1:0] LAST = IW'(TW - 1);
  state_t state;
  logic [IW-1:0] idx;
  logic tc;
  logic [TW-1:0] tt_nxt;
  gate_sweep_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != SWEEP),
    .tc(tc)
  );
  // The index runs on to 2**N_IN after the last sample, so its low bits read 0 outside SWEEP.
  assign gate_in = idx[N_IN-1:0];
  always_comb begin
    tt_nxt = truth_table;
    tt_nxt[idx[N_IN-1:0]] = gate_out;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      truth_table <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= SWEEP;
            busy <= 1'b1;
            idx <= '0;
            truth_table <= '0;
          end
        SWEEP:
          if (tc) begin
            truth_table <= tt_nxt;
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        default: begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
`ifdef GATE_SWEEP_CHECK_EN
  logic [TW-1:0] exp_q;
  always_ff @(posedge clk)
    if (!rst_n) begin
      exp_q <= '0;
      mismatch <= 1'b0;
    end else if (state == IDLE && start) begin
      exp_q <= expected;
      mismatch <= 1'b0;
    end else if (state == SWEEP && tc && idx == LAST)
      mismatch <= tt_nxt != exp_q;
`else
  logic unused_expected;
  assign unused_expected = ^expected;
  assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed checks of gate_sweep_ctrl with an AND/NAND gate model.
module tb_gate_sweep_ctrl;
  localparam bit CHK =
`ifdef GATE_SWEEP_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic gsel = 1'b0;
  logic [3:0] expected = 4'b0;
  logic busy_a, done_a, go_a, mm_a, busy_b, done_b, go_b, mm_b;
  logic [1:0] gi_a, gi_b;
  logic [3:0] tt_a, tt_b;
  int checks = 0;
  int failures = 0;
  int d1, d2;
  always #5 clk = ~clk;
  // gsel picks NAND instead of AND so the bit order of the table is exercised.
  assign go_a = gsel ? ~(gi_a[1] & gi_a[0]) : (gi_a[1] & gi_a[0]);
  assign go_b = gi_b[1] & gi_b[0];
  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .gate_in(gi_a), .gate_out(go_a), .truth_table(tt_a), .expected(expected), .mismatch(mm_a)
  );
  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .gate_in(gi_b), .gate_out(go_b), .truth_table(tt_b), .expected(expected), .mismatch(mm_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    chk("run_done", 32'(done_a), 32'd1);
  endtask
  initial begin
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_gi", 32'(gi_a), 32'd0);
    chk("rst_tt", 32'(tt_a), 32'd0);
    chk("rst_mm", 32'(mm_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst_n = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    chk("rst_nostart", 32'(busy_a), 32'd0);
    expected = 4'b1000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("basic_gi", 32'(gi_a), c <= 4 ? c - 1 : 0);
      chk("basic_busy", 32'(busy_a), 32'(c <= 4));
      chk("basic_done", 32'(done_a), 32'(c == 5));
      if (c == 5) begin
        chk("basic_tt", 32'(tt_a), 32'h8);
        chk("basic_mm", 32'(mm_a), 32'd0);
      end
      tick();
    end
    expected = 4'b1110;
    run_a();
    chk("chk_tt", 32'(tt_a), 32'h8);
    chk("chk_mm_done", 32'(mm_a), 32'(CHK));
    repeat (3) tick();
    chk("chk_mm_hold", 32'(mm_a), 32'(CHK));
    chk("chk_tt_hold", 32'(tt_a), 32'h8);
    expected = 4'b1000;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("chk_mm_clr", 32'(mm_a), 32'd0);
    chk("chk_tt_clr", 32'(tt_a), 32'd0);
    repeat (4) tick();
    chk("chk_mm_ok", 32'(mm_a), 32'd0);
    tick();
    gsel = 1'b1;
    expected = 4'b0111;
    run_a();
    chk("nand_tt", 32'(tt_a), 32'h7);
    chk("nand_mm", 32'(mm_a), 32'd0);
    tick();
    gsel = 1'b0;
    d1 = -1;
    d2 = -1;
    start_a = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done_a) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    start_a = 1'b0;
    chk("held_first", 32'(d1), 32'd5);
    chk("held_period", 32'(d2 - d1), 32'd6);
    repeat (6) tick();
    chk("held_idle", 32'(busy_a), 32'd0);
    gsel = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("mid_gi", 32'(gi_a), 32'd2);
    chk("mid_tt", 32'(tt_a), 32'h3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_gi0", 32'(gi_a), 32'd0);
    chk("mid_tt0", 32'(tt_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_nodone", 32'(done_a), 32'd0);
      tick();
    end
    gsel = 1'b0;
    expected = 4'b1000;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("slow_gi", 32'(gi_b), c <= 12 ? (c - 1) / 3 : 0);
      chk("slow_busy", 32'(busy_b), 32'(c <= 12));
      chk("slow_done", 32'(done_b), 32'(c == 13));
      if (c == 13) begin
        chk("slow_tt", 32'(tt_b), 32'h8);
        chk("slow_mm", 32'(mm_b), 32'd0);
      end
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
